// File: rtl/xor_frame_accumulator.sv
// Folds each frame of WIDTH-bit words into one word by bitwise XOR and presents
// the result with a parity bit and word count over a valid/ready output port.
module xor_frame_accumulator #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ODD       = 0,
    localparam int CW       = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_parity,
    output logic [CW-1:0]    out_count
);

    localparam logic          ODD_BIT  = (ODD != 0);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             par_q, par_d;
    logic [CW-1:0]    ocnt_q, ocnt_d;
    logic [WIDTH-1:0] fold;
    logic [CW-1:0]    cnt_inc;

    function automatic logic parity_of(input logic [WIDTH-1:0] w);
        return (^w) ^ ODD_BIT;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            par_q   <= ODD_BIT;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            par_q   <= par_d;
            ocnt_q  <= ocnt_d;
        end
    end

    // Handshake flags depend only on the state register (and rst), never on the other port.
    assign in_ready   = (state_q == ACCUM) && !rst;
    assign out_valid  = (state_q == HOLD);
    assign out_word   = word_q;
    assign out_parity = par_q;
    assign out_count  = ocnt_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        par_d   = par_q;
        ocnt_d  = ocnt_q;
        fold    = acc_q ^ in_data;
        cnt_inc = cnt_q + 1'b1;
        case (state_q)
            ACCUM: begin
                if (in_valid && in_ready) begin
                    acc_d = fold;
                    cnt_d = cnt_inc;
                    // A frame closes on in_last or on the FRAME_LEN-th word, whichever comes first.
                    if (in_last || (cnt_q == LAST_CNT)) begin
                        word_d  = fold;
                        par_d   = parity_of(fold);
                        ocnt_d  = cnt_inc;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

endmodule
